// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin merge of N_MASTERS peripheral request ports into one registered
// request slot towards the HWPE control slave; responses are routed back by one-hot id.
module hwpe_ctrl_periph_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int ID_WIDTH  = N_MASTERS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [N_MASTERS-1:0]      m_req_i,
    output logic [N_MASTERS-1:0]      m_gnt_o,
    input  logic [N_MASTERS*AW-1:0]   m_add_i,
    input  logic [N_MASTERS-1:0]      m_wen_i,
    input  logic [N_MASTERS*DW/8-1:0] m_be_i,
    input  logic [N_MASTERS*DW-1:0]   m_data_i,
    output logic [N_MASTERS-1:0]      m_r_valid_o,
    output logic [DW-1:0]             m_r_data_o,
    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    output logic [AW-1:0]             s_add_o,
    output logic                      s_wen_o,
    output logic [DW/8-1:0]           s_be_o,
    output logic [DW-1:0]             s_data_o,
    output logic [ID_WIDTH-1:0]       s_id_o,
    input  logic                      s_r_valid_i,
    input  logic [ID_WIDTH-1:0]       s_r_id_i,
    input  logic [DW-1:0]             s_r_data_i
);

    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int BW    = DW / 8;

    logic                req_q, req_d;
    logic [AW-1:0]       add_q, add_d;
    logic                wen_q, wen_d;
    logic [BW-1:0]       be_q, be_d;
    logic [DW-1:0]       data_q, data_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic             found_hi, found_lo;
    logic [PTR_W-1:0] hi_idx, lo_idx, winner;
    logic             slot_accept, grant_en;

    // Two-pass scan: lowest requester at or above rr_ptr, else lowest requester overall.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_req_i[i]) begin
                found_lo = 1'b1;
                lo_idx   = PTR_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    found_hi = 1'b1;
                    hi_idx   = PTR_W'(i);
                end
            end
        end
        winner = found_hi ? hi_idx : lo_idx;
    end

    // A busy slot taken by the slave this cycle can be refilled without a bubble.
    assign slot_accept = ~clear_i & (~req_q | s_gnt_i);
    assign grant_en    = slot_accept & found_lo;
    assign m_gnt_o     = grant_en ? (N_MASTERS'(1) << winner) : '0;

    always_comb begin
        req_d    = req_q;
        add_d    = add_q;
        wen_d    = wen_q;
        be_d     = be_q;
        data_d   = data_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (clear_i) begin
            req_d    = 1'b0;
            rr_ptr_d = '0;
        end else if (grant_en) begin
            req_d    = 1'b1;
            add_d    = m_add_i[winner*AW +: AW];
            wen_d    = m_wen_i[winner];
            be_d     = m_be_i[winner*BW +: BW];
            data_d   = m_data_i[winner*DW +: DW];
            id_d     = ID_WIDTH'(1) << winner;
            rr_ptr_d = (int'(winner) == N_MASTERS - 1) ? '0 : winner + 1'b1;
        end else if (req_q && s_gnt_i) begin
            req_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q    <= 1'b0;
            add_q    <= '0;
            wen_q    <= 1'b0;
            be_q     <= '0;
            data_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            req_q    <= req_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            be_q     <= be_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign s_req_o  = req_q;
    assign s_add_o  = add_q;
    assign s_wen_o  = wen_q;
    assign s_be_o   = be_q;
    assign s_data_o = data_q;
    assign s_id_o   = id_q;

    assign m_r_valid_o = {N_MASTERS{s_r_valid_i}} & s_r_id_i[N_MASTERS-1:0];
    assign m_r_data_o  = s_r_data_i;

endmodule
